decode_stage: RTL



---
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: regfile read addressing, WB bypass,
// subset decode, load-use stall and ID/EX register with valid/ready.
module decode_stage #(
  parameter int unsigned ENABLE_BYPASS = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [31:0] Instruction,
  output logic [4:0]  ReadRegister1,
  output logic [4:0]  ReadRegister2,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbRegWrite,
  input  logic [4:0]  WbWriteRegister,
  input  logic [31:0] WbWriteData,
  output logic        ExValid,
  input  logic        ExReady,
  output logic [31:0] ExOpA,
  output logic [31:0] ExOpB,
  output logic [31:0] ExImm,
  output logic [4:0]  ExRd,
  output logic [2:0]  ExAluOp,
  output logic        ExAluSrc,
  output logic        ExRegWrite,
  output logic        ExMemRead,
  output logic        ExMemWrite
);

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } id_ex_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;

  assign opcode = Instruction[31:26];
  assign funct  = Instruction[5:0];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];

  assign ReadRegister1 = rs;
  assign ReadRegister2 = rt;

  logic is_r;
  logic is_addi;
  logic is_ori;
  logic is_lw;
  logic is_sw;

  assign is_r    = (opcode == OP_R);
  assign is_addi = (opcode == OP_ADDI);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);

  logic bypass_en;
  logic fwd_a;
  logic fwd_b;

  assign bypass_en = (ENABLE_BYPASS != 0);
  assign fwd_a = bypass_en && WbRegWrite &&
                 (WbWriteRegister != 5'd0) &&
                 (WbWriteRegister == rs);
  assign fwd_b = bypass_en && WbRegWrite &&
                 (WbWriteRegister != 5'd0) &&
                 (WbWriteRegister == rt);

  id_ex_t dec;

  always_comb begin
    dec         = '0;
    dec.op_a    = fwd_a ? WbWriteData : ReadData1;
    dec.op_b    = fwd_b ? WbWriteData : ReadData2;
    dec.imm     = {{16{Instruction[15]}}, Instruction[15:0]};
    unique case (1'b1)
      is_r: begin
        dec.rd        = Instruction[15:11];
        dec.reg_write = 1'b1;
        unique case (funct)
          6'h20: dec.alu_op = ALU_ADD;
          6'h22: dec.alu_op = ALU_SUB;
          6'h24: dec.alu_op = ALU_AND;
          6'h25: dec.alu_op = ALU_OR;
          6'h2A: dec.alu_op = ALU_SLT;
          default: begin
            dec.rd        = 5'd0;
            dec.reg_write = 1'b0;
          end
        endcase
      end
      is_addi: begin
        dec.rd        = rt;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_ori: begin
        dec.imm       = {16'h0000, Instruction[15:0]};
        dec.alu_op    = ALU_OR;
        dec.rd        = rt;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      is_lw: begin
        dec.rd        = rt;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      is_sw: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      default: ;
    endcase
    // $zero is never a real destination
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  id_ex_t ex_d;
  id_ex_t ex_q;
  logic   ex_valid_d;
  logic   ex_valid_q;
  logic   advance;
  logic   uses_rt;
  logic   stall;
  logic   accept;

  assign advance = !ex_valid_q || ExReady;
  assign uses_rt = is_r || is_sw;
  assign stall   = ex_valid_q && ex_q.mem_read &&
                   (ex_q.rd != 5'd0) &&
                   ((ex_q.rd == rs) ||
                    (uses_rt && (ex_q.rd == rt)));

  assign InstrReady = advance && !stall && !Reset;
  assign accept     = InstrValid && InstrReady;

  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (advance) begin
      ex_valid_d = accept;
      if (accept) ex_d = dec;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ExValid    = ex_valid_q;
  assign ExOpA      = ex_q.op_a;
  assign ExOpB      = ex_q.op_b;
  assign ExImm      = ex_q.imm;
  assign ExRd       = ex_q.rd;
  assign ExAluOp    = ex_q.alu_op;
  assign ExAluSrc   = ex_q.alu_src;
  assign ExRegWrite = ex_q.reg_write;
  assign ExMemRead  = ex_q.mem_read;
  assign ExMemWrite = ex_q.mem_write;

endmodule
